// File: rtl/tile_update_scheduler_pkg.sv
// Shared definitions for the tile update scheduler: tile codes, map geometry,
// scheduler state encoding and the write-request payload layout.
package tile_update_scheduler_pkg;

  typedef logic [7:0] tile_t;

  // Tile codes understood by the VGA drawer.
  localparam tile_t SKY = 8'd1;
  localparam tile_t BLK = 8'd2;
  localparam tile_t GND = 8'd3;
  localparam tile_t TKN = 8'd4;
  localparam tile_t BDR = 8'd5;
  localparam tile_t CLK = 8'd6;

  localparam int MAP_ROWS           = 12;
  localparam int MAP_COLS           = 17;
  localparam int MAX_WRITES_DEFAULT = 64;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SNAP   = 2'd1,
    ARB    = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

  // True when a requested cell lies inside the tile map.
  function automatic logic cell_in_map(input logic [3:0] row, input logic [4:0] col);
    return (32'(row) < MAP_ROWS) && (32'(col) < MAP_COLS);
  endfunction

endpackage

// File: rtl/tile_update_scheduler_if.sv
// Tile write request bus shared by the two requesters and the scheduler.
// Index 0 is the block/coin logic, index 1 the level loader.
interface tile_update_scheduler_if;
  import tile_update_scheduler_pkg::*;

  logic  [1:0]      req_valid;
  logic  [1:0]      req_ready;
  logic  [1:0][3:0] req_row;
  logic  [1:0][4:0] req_col;
  tile_t [1:0]      req_tile;

  modport master (
    output req_valid,
    output req_row,
    output req_col,
    output req_tile,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_row,
    input  req_col,
    input  req_tile,
    output req_ready
  );

endinterface

// File: rtl/tile_update_scheduler_rr_arbiter2.sv
// Two-way round-robin grant selection. Purely combinational; the caller owns
// the last_grant register and updates it on each transfer.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant
);

  // Contention goes to whichever requester was not served last.
  always_comb begin
    grant_valid = |req;
    grant       = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/tile_update_scheduler.sv
// Tile update scheduler: owns the background tile map and frame-stable sprite
// positions. Tile writes from two requesters are applied only during vertical
// blank, and positions are captured once at vblank entry, so the drawer never
// sees a half-updated frame.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   ACTIVE | visible area, requests held off, waiting for vblank entry
//   SNAP   | one cycle: capture positions, count frame, clear budget
//   ARB    | vblank: grant and apply at most one tile write per cycle
//   DONE   | write budget used up, waiting for vblank to end
module tile_update_scheduler
  import tile_update_scheduler_pkg::*;
#(
  parameter int MAX_WRITES = MAX_WRITES_DEFAULT
) (
  input  logic                                  vga_clock,
  input  logic                                  reset,
  input  logic                                  vblank,
  input  int                                    mario_x_in,
  input  int                                    mario_y_in,
  input  int                                    goomba_x_in,
  input  int                                    goomba_y_in,
  tile_update_scheduler_if.slave                bus,
  output tile_t [MAP_ROWS-1:0][MAP_COLS-1:0]    background,
  output int                                    mario_x,
  output int                                    mario_y,
  output int                                    goomba_x,
  output int                                    goomba_y,
  output logic [15:0]                           frame_count,
  output logic [7:0]                            drop_count
);

  localparam int BW = $clog2(MAX_WRITES + 1);

  sched_state_e state;
  sched_state_e state_next;
  logic         vblank_q;
  logic         last_grant;
  logic         grant_valid;
  logic         grant;
  logic         transfer;
  logic [1:0]   ready;
  logic [BW-1:0] budget;
  logic [3:0]   wr_row;
  logic [4:0]   wr_col;
  tile_t        wr_tile;
  logic         wr_in_map;

  rr_arbiter2 u_arbiter (
    .req         (bus.req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign wr_row    = bus.req_row[grant];
  assign wr_col    = bus.req_col[grant];
  assign wr_tile   = bus.req_tile[grant];
  assign wr_in_map = cell_in_map(wr_row, wr_col);
  assign bus.req_ready = ready;

  // Next state and handshake decode; ready is raised only for the granted requester.
  always_comb begin
    state_next = state;
    ready      = 2'b00;
    transfer   = 1'b0;
    case (state)
      ACTIVE: begin
        if (vblank && !vblank_q) state_next = SNAP;
      end
      SNAP: begin
        state_next = ARB;
      end
      ARB: begin
        if (!vblank) begin
          state_next = ACTIVE;
        end else if (grant_valid) begin
          ready[grant] = 1'b1;
          transfer     = 1'b1;
          if (budget == BW'(MAX_WRITES - 1)) state_next = DONE;
        end
      end
      DONE: begin
        if (!vblank) state_next = ACTIVE;
      end
      default: begin
        state_next = ACTIVE;
      end
    endcase
  end

  // State register and vblank history; vblank_q resets high so a reset released inside vblank waits a frame.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      state    <= ACTIVE;
      vblank_q <= 1'b1;
    end else begin
      state    <= state_next;
      vblank_q <= vblank;
    end
  end

  // Round-robin history and per-vblank write budget.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      budget     <= '0;
    end else if (state == SNAP) begin
      budget <= '0;
    end else if (transfer) begin
      last_grant <= grant;
      budget     <= budget + 1'b1;
    end
  end

  // Tile map: in-range transfers land here, visible to the drawer the next cycle.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      background <= {(MAP_ROWS * MAP_COLS){SKY}};
    end else if (transfer && wr_in_map) begin
      background[wr_row][wr_col] <= wr_tile;
    end
  end

  // Out-of-range transfers are still accepted but only counted, saturating.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (transfer && !wr_in_map && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end

  // Sprite positions and frame counter move only in the snapshot cycle.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      mario_x     <= 0;
      mario_y     <= 0;
      goomba_x    <= 0;
      goomba_y    <= 0;
      frame_count <= 16'd0;
    end else if (state == SNAP) begin
      mario_x     <= mario_x_in;
      mario_y     <= mario_y_in;
      goomba_x    <= goomba_x_in;
      goomba_y    <= goomba_y_in;
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule
